// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: register address width, the decoded control
// bundle layout, and a helper for x0-aware register address matching.
package riscv_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W     = 16;

    // Bit positions inside the opaque decoded control bundle
    localparam int CTRL_ALU_OP_LSB = 0;
    localparam int CTRL_ALU_OP_W   = 4;
    localparam int CTRL_ALU_SRC_B  = 4;
    localparam int CTRL_MEM_WRITE  = 5;
    localparam int CTRL_REG_WRITE  = 6;
    localparam int CTRL_BRANCH     = 7;
    localparam int CTRL_JUMP       = 8;
    localparam int CTRL_FUNCT3_LSB = 9;
    localparam int CTRL_FUNCT3_W   = 3;
    localparam int CTRL_MEM_SIGNED = 12;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // x0 is hardwired to zero, so it never produces a dependency
    function automatic logic addr_hit(input reg_addr_t a, input reg_addr_t b);
        return (a != '0) && (a == b);
    endfunction
endpackage

// File: rtl/id_ex_hazard.sv
// Combinational load-use hazard detection and writeback bypass selects for the
// ID/EX register: capture-time selects on ID addresses, hold-time on EX addresses.
module id_ex_hazard import riscv_pkg::*; (
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic [REG_ADDR_W-1:0] ex_rs1_addr,
    input  logic [REG_ADDR_W-1:0] ex_rs2_addr,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  wb_regWrite,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    output logic                  haz,
    output logic                  cap_byp1,
    output logic                  cap_byp2,
    output logic                  hold_byp1,
    output logic                  hold_byp2
);
    logic w_load_held;

    assign w_load_held = ex_valid && ex_mem_read;
    assign haz = w_load_held &&
                 (addr_hit(ex_rd_addr, id_rs1_addr) || addr_hit(ex_rd_addr, id_rs2_addr));

    assign cap_byp1  = wb_regWrite && addr_hit(wb_rd_addr, id_rs1_addr);
    assign cap_byp2  = wb_regWrite && addr_hit(wb_rd_addr, id_rs2_addr);
    assign hold_byp1 = wb_regWrite && addr_hit(wb_rd_addr, ex_rs1_addr);
    assign hold_byp2 = wb_regWrite && addr_hit(wb_rd_addr, ex_rs2_addr);
endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with valid/ready handshake, one-bubble load-use stall
// and redirect flush. Define ID_EX_WB_BYPASS_EN to forward the writeback port.
module id_ex_pipe #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = riscv_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [WIDTH-1:0]  id_pc,
    input  logic [WIDTH-1:0]  id_imm,
    input  logic [4:0]        id_rs1_addr,
    input  logic [4:0]        id_rs2_addr,
    input  logic [4:0]        id_rd_addr,
    input  logic [WIDTH-1:0]  id_rs1_data,
    input  logic [WIDTH-1:0]  id_rs2_data,
    input  logic              id_mem_read,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_regWrite,
    input  logic [4:0]        wb_rd_addr,
    input  logic [WIDTH-1:0]  wb_write_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [WIDTH-1:0]  ex_pc,
    output logic [WIDTH-1:0]  ex_imm,
    output logic [WIDTH-1:0]  ex_rs1_data,
    output logic [WIDTH-1:0]  ex_rs2_data,
    output logic [4:0]        ex_rs1_addr,
    output logic [4:0]        ex_rs2_addr,
    output logic [4:0]        ex_rd_addr,
    output logic              ex_mem_read,
    output logic [CTRL_W-1:0] ex_ctrl
);
    logic              r_ex_valid, r_mem_read;
    logic [WIDTH-1:0]  r_pc, r_imm, r_rs1_data, r_rs2_data;
    logic [4:0]        r_rs1_addr, r_rs2_addr, r_rd_addr;
    logic [CTRL_W-1:0] r_ctrl;

    logic             w_adv, w_haz, w_cap;
    logic             w_cap_byp1, w_cap_byp2, w_hold_byp1, w_hold_byp2;
    logic             w_upd1, w_upd2;
    logic [WIDTH-1:0] w_rs1_cap, w_rs2_cap;

    id_ex_hazard u_hazard (
        .ex_valid    (r_ex_valid),
        .ex_mem_read (r_mem_read),
        .ex_rd_addr  (r_rd_addr),
        .ex_rs1_addr (r_rs1_addr),
        .ex_rs2_addr (r_rs2_addr),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .wb_regWrite (wb_regWrite),
        .wb_rd_addr  (wb_rd_addr),
        .haz         (w_haz),
        .cap_byp1    (w_cap_byp1),
        .cap_byp2    (w_cap_byp2),
        .hold_byp1   (w_hold_byp1),
        .hold_byp2   (w_hold_byp2)
    );

    assign w_adv    = !r_ex_valid || ex_ready;
    assign id_ready = w_adv && !w_haz && !flush;
    assign w_cap    = id_valid && id_ready;

`ifdef ID_EX_WB_BYPASS_EN
    assign w_rs1_cap = w_cap_byp1 ? wb_write_data : id_rs1_data;
    assign w_rs2_cap = w_cap_byp2 ? wb_write_data : id_rs2_data;
    assign w_upd1    = w_hold_byp1;
    assign w_upd2    = w_hold_byp2;
`else
    logic w_unused_byp;
    assign w_unused_byp = ^{w_cap_byp1, w_cap_byp2, w_hold_byp1, w_hold_byp2};
    assign w_rs1_cap    = id_rs1_data;
    assign w_rs2_cap    = id_rs2_data;
    assign w_upd1       = 1'b0;
    assign w_upd2       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex_valid <= 1'b0;
            r_pc       <= '0;
            r_imm      <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rd_addr  <= '0;
            r_mem_read <= 1'b0;
            r_ctrl     <= '0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_cap) begin
            r_ex_valid <= 1'b1;
            r_pc       <= id_pc;
            r_imm      <= id_imm;
            r_rs1_data <= w_rs1_cap;
            r_rs2_data <= w_rs2_cap;
            r_rs1_addr <= id_rs1_addr;
            r_rs2_addr <= id_rs2_addr;
            r_rd_addr  <= id_rd_addr;
            r_mem_read <= id_mem_read;
            r_ctrl     <= id_ctrl;
        end else if (w_adv) begin
            r_ex_valid <= 1'b0;
        end else begin
            // Holding under backpressure: keep operands fresh against WB writes
            if (w_upd1) r_rs1_data <= wb_write_data;
            if (w_upd2) r_rs2_data <= wb_write_data;
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_pc       = r_pc;
    assign ex_imm      = r_imm;
    assign ex_rs1_data = r_rs1_data;
    assign ex_rs2_data = r_rs2_data;
    assign ex_rs1_addr = r_rs1_addr;
    assign ex_rs2_addr = r_rs2_addr;
    assign ex_rd_addr  = r_rd_addr;
    assign ex_mem_read = r_mem_read;
    assign ex_ctrl     = r_ctrl;
endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: accepted instructions are queued with their
// expected EX image and compared every cycle the stage reports them valid.
module tb_id_ex_pipe;
    logic        clk, rst;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_mem_read;
    logic [15:0] id_ctrl;
    logic        wb_regWrite;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_write_data;
    logic        flush, ex_ready, ex_valid;
    logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic        ex_mem_read;
    logic [15:0] ex_ctrl;

    typedef struct packed {
        logic [31:0] pc, imm, r1d, r2d;
        logic [4:0]  r1a, r2a, rda;
        logic        mr;
        logic [15:0] ctrl;
    } txn_t;

    txn_t q[$];
    int   nchk = 0;
    int   nbad = 0;

`ifdef ID_EX_WB_BYPASS_EN
    localparam logic [31:0] EXP_CAP  = 32'hDEADBEEF;
    localparam logic [31:0] EXP_HOLD = 32'h12345678;
`else
    localparam logic [31:0] EXP_CAP  = 32'h00000007;
    localparam logic [31:0] EXP_HOLD = 32'h00000007;
`endif

    id_ex_pipe #(.WIDTH(32), .CTRL_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_mem_read(id_mem_read), .id_ctrl(id_ctrl),
        .wb_regWrite(wb_regWrite), .wb_rd_addr(wb_rd_addr), .wb_write_data(wb_write_data),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
        .ex_mem_read(ex_mem_read), .ex_ctrl(ex_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        nchk++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] byp(input logic [4:0] a, input logic [31:0] raw);
`ifdef ID_EX_WB_BYPASS_EN
        if (wb_regWrite && wb_rd_addr != 5'd0 && wb_rd_addr == a) return wb_write_data;
`endif
        return raw;
    endfunction

    task automatic idle();
        id_valid = 1'b0; flush = 1'b0; wb_regWrite = 1'b0; wb_rd_addr = '0; wb_write_data = '0;
    endtask

    task automatic ins(input logic [31:0] pc, input logic [4:0] r1a, r2a, rda,
                       input logic mr, input logic [31:0] r1d, r2d);
        id_valid = 1'b1; id_pc = pc; id_imm = {16'hFFFF, pc[15:0]};
        id_rs1_addr = r1a; id_rs2_addr = r2a; id_rd_addr = rda; id_mem_read = mr;
        id_rs1_data = r1d; id_rs2_data = r2d; id_ctrl = pc[15:0] ^ 16'h5A5A;
    endtask

    // One clock: check the current cycle against the model, then advance
    task automatic cyc();
        txn_t got, t;
        logic v, adv, haz, rdy;
        #1;
        got = {ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, ex_rs1_addr, ex_rs2_addr,
               ex_rd_addr, ex_mem_read, ex_ctrl};
        v   = (q.size() != 0);
        chk("ex_valid", {159'd0, ex_valid}, {159'd0, v});
        adv = !v || ex_ready;
        haz = 1'b0;
        if (v) haz = q[0].mr && q[0].rda != 5'd0 &&
                     (q[0].rda == id_rs1_addr || q[0].rda == id_rs2_addr);
        rdy = adv && !haz && !flush;
        chk("id_ready", {159'd0, id_ready}, {159'd0, rdy});
        if (v) chk("ex_fields", got, q[0]);
        if (v && ex_ready) void'(q.pop_front());
        if (flush) begin
            q.delete();
        end else if (v && !ex_ready) begin
`ifdef ID_EX_WB_BYPASS_EN
            t = q[0];
            if (wb_regWrite && wb_rd_addr != 5'd0 && wb_rd_addr == t.r1a) t.r1d = wb_write_data;
            if (wb_regWrite && wb_rd_addr != 5'd0 && wb_rd_addr == t.r2a) t.r2d = wb_write_data;
            q[0] = t;
`endif
        end else if (id_valid && rdy) begin
            t = '{pc: id_pc, imm: id_imm, r1d: byp(id_rs1_addr, id_rs1_data),
                  r2d: byp(id_rs2_addr, id_rs2_data), r1a: id_rs1_addr, r2a: id_rs2_addr,
                  rda: id_rd_addr, mr: id_mem_read, ctrl: id_ctrl};
            q.push_back(t);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; ex_ready = 1'b1;
        idle();
        ins(32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
        id_valid = 1'b0;
        #1;
        chk("rst_state", {ex_valid, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, ex_rs1_addr,
                          ex_rs2_addr, ex_rd_addr, ex_mem_read, ex_ctrl}, '0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        cyc();

        // Streaming: ADD x3,x1,x2 ; SUB x4,x3,x1 back to back
        ins(32'h100, 5'd1, 5'd2, 5'd3, 1'b0, 32'h11, 32'h22); cyc();
        ins(32'h104, 5'd3, 5'd1, 5'd4, 1'b0, 32'h33, 32'h11); cyc();
        idle(); #1 chk("stream_sub_pc", {128'd0, ex_pc}, {128'd0, 32'h104});
        cyc(); cyc();

        // Load-use: LW x5 then ADD x6,x5,x1 -> exactly one bubble
        ins(32'h200, 5'd2, 5'd0, 5'd5, 1'b1, 32'h40, 32'h0); cyc();
        ins(32'h204, 5'd5, 5'd1, 5'd6, 1'b0, 32'h55, 32'h11);
        #1 chk("lu_stall", {159'd0, id_ready}, 160'd0);
        cyc();
        #1 chk("lu_bubble", {159'd0, ex_valid}, 160'd0);
        cyc();
        idle(); cyc(); cyc();

        // LW x0 then use of x0 -> no stall
        ins(32'h300, 5'd2, 5'd0, 5'd0, 1'b1, 32'h40, 32'h0); cyc();
        ins(32'h304, 5'd0, 5'd0, 5'd7, 1'b0, 32'h0, 32'h0);
        #1 chk("lu_x0_nostall", {159'd0, id_ready}, 160'd1);
        cyc();
        idle(); cyc(); cyc();

        // Backpressure: hold 3 cycles, then resume
        ins(32'h400, 5'd1, 5'd2, 5'd8, 1'b0, 32'hA1, 32'hA2); cyc();
        ex_ready = 1'b0;
        ins(32'h404, 5'd3, 5'd4, 5'd9, 1'b0, 32'hB1, 32'hB2);
        for (int i = 0; i < 3; i++) cyc();
        ex_ready = 1'b1; cyc();
        idle(); cyc(); cyc();

        // Flush with id_valid and ex_valid both high
        ins(32'h500, 5'd1, 5'd2, 5'd10, 1'b0, 32'h1, 32'h2); cyc();
        ins(32'h504, 5'd1, 5'd2, 5'd11, 1'b0, 32'h1, 32'h2); flush = 1'b1;
        #1 chk("flush_rdy", {159'd0, id_ready}, 160'd0);
        cyc();
        flush = 1'b0; id_valid = 1'b0;
        #1 chk("flush_kill", {159'd0, ex_valid}, 160'd0);
        cyc();
        ins(32'h504, 5'd1, 5'd2, 5'd11, 1'b0, 32'h1, 32'h2); cyc();
        idle(); cyc();

        // Flush overrides hold; flush together with a load-use hazard
        ins(32'h600, 5'd1, 5'd2, 5'd12, 1'b0, 32'h1, 32'h2); cyc();
        idle(); ex_ready = 1'b0; flush = 1'b1; cyc();
        flush = 1'b0; ex_ready = 1'b1; cyc();
        ins(32'h700, 5'd1, 5'd0, 5'd5, 1'b1, 32'h1, 32'h0); cyc();
        ins(32'h704, 5'd5, 5'd0, 5'd6, 1'b0, 32'h1, 32'h0); flush = 1'b1; cyc();
        idle(); cyc();

        // Writeback bypass at capture, during hold, and ignored for x0
        ins(32'h800, 5'd7, 5'd1, 5'd13, 1'b0, 32'h7, 32'h9);
        wb_regWrite = 1'b1; wb_rd_addr = 5'd7; wb_write_data = 32'hDEADBEEF; cyc();
        idle(); ex_ready = 1'b0;
        #1 chk("byp_cap", {128'd0, ex_rs1_data}, {128'd0, EXP_CAP});
        wb_regWrite = 1'b1; wb_rd_addr = 5'd7; wb_write_data = 32'h12345678; cyc();
        #1 chk("byp_hold", {128'd0, ex_rs1_data}, {128'd0, EXP_HOLD});
        wb_rd_addr = 5'd0; wb_write_data = 32'h0BAD0BAD; cyc();
        #1 chk("byp_x0_hold", {128'd0, ex_rs1_data}, {128'd0, EXP_HOLD});
        wb_regWrite = 1'b0; ex_ready = 1'b1; cyc();
        ins(32'h900, 5'd0, 5'd0, 5'd14, 1'b0, 32'h55, 32'h66);
        wb_regWrite = 1'b1; wb_rd_addr = 5'd0; wb_write_data = 32'hCAFE; cyc();
        ins(32'h904, 5'd9, 5'd9, 5'd15, 1'b0, 32'h1, 32'h2);
        wb_regWrite = 1'b1; wb_rd_addr = 5'd9; wb_write_data = 32'hF00D; cyc();
        idle(); cyc(); cyc();

        // Async reset between edges while an instruction is held
        ins(32'hA00, 5'd1, 5'd2, 5'd16, 1'b1, 32'h3, 32'h4); cyc();
        idle(); ex_ready = 1'b0;
        #2 rst = 1'b0;
        #1 chk("async_rst", {ex_valid, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, ex_rs1_addr,
                             ex_rs2_addr, ex_rd_addr, ex_mem_read, ex_ctrl}, '0);
        q.delete();
        @(negedge clk);
        rst = 1'b1; ex_ready = 1'b1;
        ins(32'hB00, 5'd1, 5'd2, 5'd17, 1'b0, 32'h5, 32'h6); cyc();
        idle(); cyc(); cyc();

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end
endmodule
